// File: rtl/soat_instr_encoder_if.sv
// Field-set stream in, instruction-memory write port and session status out.
// The encoder takes the slave modport and the loader or bench takes the master modport.
interface soat_instr_encoder_if #(parameter int AW = 8);
  logic          start;
  logic [AW-1:0] base_addr;
  logic          finish;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    opcode;
  logic [2:0]    funct;
  logic [2:0]    rs;
  logic [2:0]    rt;
  logic [2:0]    rd;
  logic [5:0]    imm;
  logic [11:0]   target;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic [AW:0]   word_count;
  logic          full;
  logic          busy;
  logic          err_illegal;

  modport master (
    output start, base_addr, finish, in_valid, opcode, funct, rs, rt, rd, imm, target,
    input  in_ready, imem_we, imem_addr, imem_wdata, word_count, full, busy, err_illegal
  );

  modport slave (
    input  start, base_addr, finish, in_valid, opcode, funct, rs, rt, rd, imm, target,
    output in_ready, imem_we, imem_addr, imem_wdata, word_count, full, busy, err_illegal
  );
endinterface

// File: rtl/soat_instr_encoder.sv
// Packs SOAT field sets into 16-bit words and writes them sequentially to instruction memory.
// Define ENC_CHECK_EN to drop illegal field sets with an err_illegal pulse instead of writing them.
//
//   state  | meaning
//   IDLE   | after reset, no session yet
//   RUN    | session open, accepting field sets and writing words
//   DONE   | session closed, outputs held until the next start
module soat_instr_encoder #(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input logic                  clk,
  input logic                  rst_n,
  soat_instr_encoder_if.slave  enc
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic          fin_q, fin_d;

  logic [15:0]   word;
  logic          illegal;
  logic          full;
  logic          in_ready;
  logic          xfer;

  always_comb begin
    word = {enc.opcode, 12'h000};
    case (enc.opcode)
      4'h0, 4'hD:                   word = {enc.opcode, enc.rs, enc.rt, enc.rd, enc.funct};
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
      4'h6, 4'h7, 4'h8, 4'h9:       word = {enc.opcode, enc.rs, enc.rt, enc.imm};
      4'hA, 4'hB:                   word = {enc.opcode, enc.target};
      4'hC:                         word = {enc.opcode, enc.rs, 9'b0};
      default:                      word = {enc.opcode, 12'h000};
    endcase
  end

`ifdef ENC_CHECK_EN
  assign illegal = (enc.opcode == 4'hE) || (enc.opcode == 4'hF) ||
                   ((enc.opcode == 4'hD) && (enc.funct >= 3'd3)) ||
                   ((enc.opcode == 4'hC) && ((enc.rt | enc.rd) != 3'd0));
`else
  assign illegal = 1'b0;
`endif

  assign full     = (cnt_q == DEPTH_W);
  assign in_ready = (state_q == S_RUN) && !full && !fin_q;
  assign xfer     = enc.in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    err_d    = 1'b0;
    fin_d    = fin_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (enc.start) begin
          state_d  = S_RUN;
          wr_ptr_d = enc.base_addr;
          cnt_d    = '0;
          fin_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            we_d     = 1'b1;
            addr_d   = wr_ptr_q;
            wdata_d  = word;
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
          end
        end
        if (enc.finish) fin_d = 1'b1;
        // A word written this cycle is already on the bus, so closing now never loses it.
        if ((enc.finish || fin_q) && !xfer) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      err_q    <= err_d;
      fin_q    <= fin_d;
    end
  end

  assign enc.in_ready    = in_ready;
  assign enc.imem_we     = we_q;
  assign enc.imem_addr   = addr_q;
  assign enc.imem_wdata  = wdata_q;
  assign enc.word_count  = cnt_q;
  assign enc.full        = full;
  assign enc.busy        = (state_q == S_RUN);
  assign enc.err_illegal = err_q;

endmodule
